// File: rtl/fp16_mul_seq.sv
// Byte-serial FP16 multiply sequencer: gathers two FP16 operands a byte at a time, launches an
// external multiplier, and returns the product low byte first. `FP_ZERO_BYPASS_EN` short-circuits zero operands.
module fp16_mul_seq #(
  parameter int MUL_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        start,
  input  logic [7:0]  a_byte,
  input  logic [7:0]  b_byte,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_start,
  input  logic        mul_done,
  input  logic [15:0] mul_result,
  output logic [7:0]  res_byte,
  output logic        res_valid,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_HI = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    OUT_LO  = 3'd4,
    OUT_HI  = 3'd5
  } state_t;

  // Last WAIT cycle index before the multiplier is declared hung.
  localparam logic [7:0] TO_LAST = 8'(MUL_TIMEOUT - 1);

  state_t      state;
  logic [15:0] result;
  logic [7:0]  cnt;
  logic        mul_start_q;
  logic        res_valid_q;
  logic [7:0]  res_byte_q;

`ifdef FP_ZERO_BYPASS_EN
  logic [15:0] a_full;
  logic [15:0] b_full;
  logic        zero_hit;

  assign a_full   = {a_byte, mul_a[7:0]};
  assign b_full   = {b_byte, mul_b[7:0]};
  assign zero_hit = (a_full[14:0] == 15'd0) || (b_full[14:0] == 15'd0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mul_a       <= 16'h0000;
      mul_b       <= 16'h0000;
      result      <= 16'h0000;
      cnt         <= 8'h00;
      mul_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_byte_q  <= 8'h00;
      err         <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (start) begin
            mul_a[7:0] <= a_byte;
            mul_b[7:0] <= b_byte;
            err        <= 1'b0;
            cnt        <= 8'h00;
            state      <= LOAD_HI;
          end
        end
        LOAD_HI: begin
          mul_a[15:8] <= a_byte;
          mul_b[15:8] <= b_byte;
`ifdef FP_ZERO_BYPASS_EN
          if (zero_hit) begin
            result      <= {a_byte[7] ^ b_byte[7], 15'h0000};
            res_byte_q  <= 8'h00;
            res_valid_q <= 1'b1;
            state       <= OUT_LO;
          end else begin
            mul_start_q <= 1'b1;
            state       <= ISSUE;
          end
`else
          mul_start_q <= 1'b1;
          state       <= ISSUE;
`endif
        end
        ISSUE: begin
          mul_start_q <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          // A done arriving on the final timeout cycle still delivers the real product.
          if (mul_done) begin
            result      <= mul_result;
            res_byte_q  <= mul_result[7:0];
            res_valid_q <= 1'b1;
            state       <= OUT_LO;
          end else if (cnt == TO_LAST) begin
            err         <= 1'b1;
            result      <= 16'h7E00;
            res_byte_q  <= 8'h00;
            res_valid_q <= 1'b1;
            state       <= OUT_LO;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        OUT_LO: begin
          res_byte_q <= result[15:8];
          state      <= OUT_HI;
        end
        OUT_HI: begin
          res_valid_q <= 1'b0;
          res_byte_q  <= 8'h00;
          state       <= IDLE;
        end
        default: begin
          mul_start_q <= 1'b0;
          res_valid_q <= 1'b0;
          res_byte_q  <= 8'h00;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Pulses are masked while frozen so a stalled ISSUE/OUT state never leaks a second strobe.
  assign mul_start = mul_start_q & ena;
  assign res_valid = res_valid_q & ena;
  assign res_byte  = res_valid ? res_byte_q : 8'h00;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fp16_mul_seq.sv
// Scoreboard bench for fp16_mul_seq: the driver pushes the expected product and timing, a
// responder plays the multiplier, and a monitor pops and checks every serialized result.
module tb_fp16_mul_seq;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic [7:0]  a_byte;
  logic [7:0]  b_byte;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_start;
  logic        mul_done;
  logic [15:0] mul_result;
  logic [7:0]  res_byte;
  logic        res_valid;
  logic        busy;
  logic        err;

  fp16_mul_seq #(.MUL_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .a_byte(a_byte), .b_byte(b_byte), .mul_a(mul_a), .mul_b(mul_b),
    .mul_start(mul_start), .mul_done(mul_done), .mul_result(mul_result),
    .res_byte(res_byte), .res_valid(res_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          cyc;
    logic [15:0] a;
    logic [15:0] b;
    int          nms;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          n_ms = 0;
  int          resp_mode = 0;
  int          resp_delay = 3;
  logic [15:0] resp_result = 16'h4480;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Expected outcome derived from operand values and the multiplier's behaviour.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int c0);
    exp_t e;
    e.a = a; e.b = b; e.err = 1'b0; e.nms = 1;
`ifdef FP_ZERO_BYPASS_EN
    if (a[14:0] == 15'd0 || b[14:0] == 15'd0) begin
      e.res = {a[15] ^ b[15], 15'h0000};
      e.cyc = c0 + 2;
      e.nms = 0;
      return e;
    end
`endif
    if (resp_mode == 1) begin
      e.res = resp_result;
      e.cyc = c0 + 8;
    end else if (resp_delay >= 1 && resp_delay <= T) begin
      e.res = resp_result;
      e.cyc = c0 + 3 + resp_delay;
    end else begin
      e.res = 16'h7E00;
      e.err = 1'b1;
      e.cyc = c0 + 3 + T;
    end
    return e;
  endfunction

  // Multiplier model; also owns ena so the freeze window lines up with the launch.
  initial begin
    ena = 1'b1; mul_done = 1'b0; mul_result = 16'h0000;
    forever begin
      @(negedge clk);
      if (mul_start) begin
        if (resp_mode == 1) begin
          @(posedge clk); #1 ena = 1'b0;
          @(posedge clk); #1 mul_done = 1'b1; mul_result = ~resp_result;
          @(posedge clk); #1 mul_done = 1'b0;
          @(posedge clk); #1;
          @(posedge clk); #1 ena = 1'b1; mul_done = 1'b1; mul_result = resp_result;
          @(posedge clk); #1;
          @(posedge clk); #1 mul_done = 1'b0;
        end else if (resp_delay >= 1) begin
          repeat (resp_delay) @(posedge clk);
          #1 mul_done = 1'b1; mul_result = resp_result;
          @(posedge clk); #1 mul_done = 1'b0; mul_result = 16'($urandom);
        end
      end
    end
  end

  // Monitor: pops one expectation per two-byte result burst.
  initial begin
    exp_t cur;
    int   phase = 0;
    forever begin
      @(negedge clk);
      if (mul_start) n_ms++;
      if (!ena) begin
        chk("frozen_strobes", {30'd0, mul_start, res_valid}, 32'd0);
      end
      if (!res_valid) begin
        chk("res_byte_idle", {24'd0, res_byte}, 32'd0);
        if (phase == 1) begin
          chk("hi_byte_missing", 32'd0, 32'd1);
          phase = 0;
        end
      end else if (phase == 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          cur = sb.pop_front();
          chk("lo_latency", cyc, cur.cyc);
          chk("res_lo", {24'd0, res_byte}, {24'd0, cur.res[7:0]});
          chk("mul_a_stable", {16'd0, mul_a}, {16'd0, cur.a});
          chk("mul_b_stable", {16'd0, mul_b}, {16'd0, cur.b});
          phase = 1;
        end
      end else begin
        chk("hi_latency", cyc, cur.cyc + 1);
        chk("res_hi", {24'd0, res_byte}, {24'd0, cur.res[15:8]});
        chk("err_flag", {31'd0, err}, {31'd0, cur.err});
        phase = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic txn(input logic [15:0] a, input logic [15:0] b, input bit rel);
    exp_t e;
    int   m0;
    @(posedge clk); #1;
    if (rel) rst_n = 1'b1;
    start = 1'b1; a_byte = a[7:0]; b_byte = b[7:0];
    m0 = n_ms;
    e = model(a, b, cyc);
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; a_byte = a[15:8]; b_byte = b[15:8];
    @(negedge clk);
    chk("err_cleared", {31'd0, err}, 32'd0);
    chk("busy_load", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    a_byte = 8'($urandom); b_byte = 8'($urandom);
    wait_idle();
    chk("mul_start_count", n_ms - m0, e.nms);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mul_a", {16'd0, mul_a}, 32'd0);
    chk("rst_mul_b", {16'd0, mul_b}, 32'd0);
    chk("rst_strobes", {30'd0, mul_start, res_valid}, 32'd0);
    chk("rst_res_byte", {24'd0, res_byte}, 32'd0);
    chk("rst_busy_err", {30'd0, busy, err}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a_byte = 8'h00; b_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs();

    // Directed product, accepted on the first edge after reset release.
    resp_delay = 3; resp_result = 16'h4480;
    txn(16'h3E00, 16'h4200, 1'b1);

    // Signed zero operand: bypassed or multiplied depending on the build.
    resp_delay = 3; resp_result = 16'h5A5A;
    txn(16'h8000, 16'h4200, 1'b0);

    // Multiplier never answers, err stays set until the next accepted start.
    resp_delay = 0;
    txn(16'h1234, 16'h5678, 1'b0);
    @(negedge clk);
    chk("err_sticky", {31'd0, err}, 32'd1);
    resp_delay = 2; resp_result = 16'h3C01;
    txn(16'h3C00, 16'h3C01, 1'b0);

    // Done on the last allowed WAIT cycle, then one cycle too late.
    resp_delay = T;     resp_result = 16'h1357;
    txn(16'h4000, 16'h4100, 1'b0);
    resp_delay = T + 1; resp_result = 16'h2468;
    txn(16'h4000, 16'h4100, 1'b0);

    // Freeze during WAIT with a stray done pulse.
    resp_mode = 1; resp_result = 16'hABCD;
    txn(16'h3C00, 16'h4000, 1'b0);
    resp_mode = 0;

    // Asynchronous reset mid-WAIT, then a clean transaction.
    resp_delay = 0;
    @(posedge clk); #1 start = 1'b1; a_byte = 8'h00; b_byte = 8'h00;
    @(posedge clk); #1 start = 1'b0; a_byte = 8'h3E; b_byte = 8'h42;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs();
    resp_delay = 3; resp_result = 16'h4480;
    txn(16'h3E00, 16'h4200, 1'b1);

    // start held high across three back-to-back transactions.
    resp_delay = 4; resp_result = 16'h4E4E;
    @(posedge clk); #1 start = 1'b1; a_byte = 8'h3C; b_byte = 8'h40;
    for (int i = 0; i < 3; i++) begin
      int m0;
      m0 = n_ms;
      sb.push_back(model(16'h3C3C, 16'h4040, cyc));
      @(posedge clk); #1;
      wait_idle();
      chk("held_start_count", n_ms - m0, 1);
    end
    start = 1'b0;

    // Randomized operands, latencies and products.
    for (int i = 0; i < 24; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 4) == 0) a[14:0] = 15'd0;
      if ($urandom_range(0, 4) == 0) b[14:0] = 15'd0;
      resp_delay  = $urandom_range(1, T + 2);
      resp_result = 16'($urandom);
      txn(a, b, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
